// File: rtl/native_bus_pkg.sv
// Shared types and constants for the native-bus RAM slice: FSM states,
// fault read pattern, strobe width and small datapath helpers.
package native_bus_pkg;

  localparam int          WSTRB_W     = 4;
  localparam logic [31:0] FAULT_RDATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    if (value == 32'hFFFF_FFFF) begin
      return value;
    end else begin
      return value + 32'd1;
    end
  endfunction

  // Merge new bytes into an old word on the lanes selected by wstrb.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [WSTRB_W-1:0] wstrb);
    logic [31:0] result;
    result = old_word;
    for (int i = 0; i < WSTRB_W; i++) begin
      if (wstrb[i]) begin
        result[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        result[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/native_bus_ram_if.sv
// Native memory bus (valid/ready request-response) shared by master and RAM slave.
interface native_bus_ram_if;
  import native_bus_pkg::*;

  logic               mem_valid;
  logic               mem_instr;
  logic [31:0]        mem_addr;
  logic [31:0]        mem_wdata;
  logic [WSTRB_W-1:0] mem_wstrb;
  logic [31:0]        mem_rdata;
  logic               mem_ready;
  logic               mem_fault;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata, mem_ready, mem_fault
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata, mem_ready, mem_fault
  );

endinterface

// File: rtl/native_bus_ram_array.sv
// Single-port word RAM with byte-lane write enables and registered read data.
module native_bus_ram_array
  import native_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter     MEM_FILE   = ""
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [WSTRB_W-1:0]    we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem_r [0:(2**ADDR_WIDTH)-1];
  logic [31:0] rdata_r;

  // Read-before-write port: rdata reflects the word as it was at the access edge.
  always_ff @(posedge clk) begin
    if (en) begin
      mem_r[addr] <= merge_lanes(mem_r[addr], wdata, we);
      rdata_r     <= mem_r[addr];
    end else begin
      rdata_r     <= rdata_r;
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/native_bus_ram.sv
// Native-bus RAM slave with programmable wait states and out-of-range faulting.
// Optional access statistics when NATIVE_BUS_RAM_STATS_EN is defined.
module native_bus_ram
  import native_bus_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1,
  parameter              MEM_FILE    = ""
) (
  input  logic              clk,
  input  logic              resetn,
  native_bus_ram_if.slave   bus,
`ifdef NATIVE_BUS_RAM_STATS_EN
  output logic [31:0]       stat_ifetch,
  output logic [31:0]       stat_read,
  output logic [31:0]       stat_write,
`endif
  output logic [31:0]       fault_addr
);

  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

  state_e              state_r, state_s;
  logic [3:0]          cnt_r;
  logic [31:0]         addr_r, wdata_r;
  logic [WSTRB_W-1:0]  wstrb_r;
  logic                ready_r, fault_r, rd_ok_r, wr_ok_r;
  logic [31:0]         fault_addr_r;

  logic                access_s;
  logic [31:0]         acc_addr_s, acc_wdata_s;
  logic [WSTRB_W-1:0]  acc_wstrb_s;
  logic [31:0]         offset_s;
  logic                in_range_s;
  logic [31:0]         ram_rdata_s;
  logic [WSTRB_W-1:0]  ram_we_s;

  // Next state and access strobe; zero wait states access straight from the bus.
  always_comb begin
    state_s     = state_r;
    access_s    = 1'b0;
    acc_addr_s  = addr_r;
    acc_wdata_s = wdata_r;
    acc_wstrb_s = wstrb_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.mem_valid) begin
          if (WS_LOAD == 4'd0) begin
            access_s    = 1'b1;
            acc_addr_s  = bus.mem_addr;
            acc_wdata_s = bus.mem_wdata;
            acc_wstrb_s = bus.mem_wstrb;
            state_s     = ST_RESP;
          end else begin
            state_s     = ST_WAIT;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd1) begin
          access_s = 1'b1;
          state_s  = ST_RESP;
        end else begin
          state_s  = ST_WAIT;
        end
      end
      ST_RESP: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Shift test keeps the upper-bound compare valid even when the window reaches 2^32.
  always_comb begin
    offset_s   = acc_addr_s - BASE_ADDR;
    in_range_s = (acc_addr_s >= BASE_ADDR) && ((offset_s >> (ADDR_WIDTH + 2)) == 32'd0);
    if (access_s && resetn && in_range_s) begin
      ram_we_s = acc_wstrb_s;
    end else begin
      ram_we_s = {WSTRB_W{1'b0}};
    end
  end

  native_bus_ram_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .MEM_FILE   (MEM_FILE)
  ) u_array (
    .clk   (clk),
    .en    (access_s && resetn),
    .we    (ram_we_s),
    .addr  (offset_s[ADDR_WIDTH+1:2]),
    .wdata (acc_wdata_s),
    .rdata (ram_rdata_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Request latch, wait counter and response qualifiers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_r        <= 4'd0;
      addr_r       <= 32'd0;
      wdata_r      <= 32'd0;
      wstrb_r      <= {WSTRB_W{1'b0}};
      ready_r      <= 1'b0;
      fault_r      <= 1'b0;
      rd_ok_r      <= 1'b0;
      wr_ok_r      <= 1'b0;
      fault_addr_r <= 32'd0;
    end else begin
      ready_r <= access_s;
      fault_r <= access_s && !in_range_s;
      rd_ok_r <= access_s && in_range_s && (acc_wstrb_s == {WSTRB_W{1'b0}});
      wr_ok_r <= access_s && in_range_s && (acc_wstrb_s != {WSTRB_W{1'b0}});
      if (state_r == ST_IDLE && bus.mem_valid) begin
        addr_r  <= bus.mem_addr;
        wdata_r <= bus.mem_wdata;
        wstrb_r <= bus.mem_wstrb;
        cnt_r   <= WS_LOAD;
      end else if (state_r == ST_WAIT) begin
        cnt_r   <= cnt_r - 4'd1;
      end else begin
        cnt_r   <= cnt_r;
      end
      if (access_s && !in_range_s) begin
        fault_addr_r <= acc_addr_s;
      end else begin
        fault_addr_r <= fault_addr_r;
      end
    end
  end

  // Read data is only driven during the response cycle.
  always_comb begin
    if (ready_r && fault_r) begin
      bus.mem_rdata = FAULT_RDATA;
    end else if (ready_r && rd_ok_r) begin
      bus.mem_rdata = ram_rdata_s;
    end else begin
      bus.mem_rdata = 32'd0;
    end
  end

  assign bus.mem_ready = ready_r;
  assign bus.mem_fault = fault_r;
  assign fault_addr    = fault_addr_r;

`ifdef NATIVE_BUS_RAM_STATS_EN
  logic        instr_r;
  logic [31:0] stat_ifetch_r, stat_read_r, stat_write_r;

  // Fetch qualifier latched with the request; counted when the response issues.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      instr_r       <= 1'b0;
      stat_ifetch_r <= 32'd0;
      stat_read_r   <= 32'd0;
      stat_write_r  <= 32'd0;
    end else begin
      if (state_r == ST_IDLE && bus.mem_valid) begin
        instr_r <= bus.mem_instr;
      end else begin
        instr_r <= instr_r;
      end
      if (state_r == ST_RESP) begin
        if (rd_ok_r && instr_r)  stat_ifetch_r <= sat_inc(stat_ifetch_r);
        if (rd_ok_r && !instr_r) stat_read_r   <= sat_inc(stat_read_r);
        if (wr_ok_r)             stat_write_r  <= sat_inc(stat_write_r);
      end
    end
  end

  assign stat_ifetch = stat_ifetch_r;
  assign stat_read   = stat_read_r;
  assign stat_write  = stat_write_r;
`else
  logic instr_unused_s;
  assign instr_unused_s = bus.mem_instr;
`endif

endmodule

// File: tb/tb_native_bus_ram.sv
// Scoreboard bench: two RAM instances (2 wait states at base 0, and 0 wait
// states at a non-zero base) checked against a word-array reference model.
module tb_native_bus_ram;
  import native_bus_pkg::*;

  localparam int          AW0 = 16;
  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam int          WS0 = 2;
  localparam int          AW1 = 8;
  localparam logic [31:0] BASE1 = 32'h0000_0400;
  localparam int          WS1 = 0;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  native_bus_ram_if b0();
  native_bus_ram_if b1();
  logic [31:0] fa0, fa1;
`ifdef NATIVE_BUS_RAM_STATS_EN
  logic [31:0] si0, sr0, sw0, si1, sr1, sw1;
`endif

  native_bus_ram #(.ADDR_WIDTH(AW0), .BASE_ADDR(BASE0), .WAIT_STATES(WS0), .MEM_FILE("")) u_dut0 (
    .clk(clk), .resetn(resetn), .bus(b0),
`ifdef NATIVE_BUS_RAM_STATS_EN
    .stat_ifetch(si0), .stat_read(sr0), .stat_write(sw0),
`endif
    .fault_addr(fa0));

  native_bus_ram #(.ADDR_WIDTH(AW1), .BASE_ADDR(BASE1), .WAIT_STATES(WS1), .MEM_FILE("")) u_dut1 (
    .clk(clk), .resetn(resetn), .bus(b1),
`ifdef NATIVE_BUS_RAM_STATS_EN
    .stat_ifetch(si1), .stat_read(sr1), .stat_write(sw1),
`endif
    .fault_addr(fa1));

  typedef struct {
    logic [31:0] rdata;
    logic        chk_data;
    logic        fault;
    logic [31:0] faddr;
    int          due;
  } exp_t;

  exp_t        q0[$], q1[$];
  logic [31:0] m0[int unsigned];
  logic [31:0] m1[int unsigned];
  logic [31:0] lf0, lf1;
  int          cyc = 0;
  int          n_checks = 0, n_pass = 0;
  int          cnt_if = 0, cnt_rd = 0, cnt_wr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  function automatic logic in_rng(input logic [31:0] addr, input logic [31:0] base, input int aw);
    return (addr >= base) && ((longint'(addr) - longint'(base)) < (longint'(4) << aw));
  endfunction

  // Monitor for instance 0.
  always @(negedge clk) begin : mon0
    exp_t e;
    if (b0.mem_ready === 1'b1) begin
      if (q0.size() == 0) begin
        check("d0_unexpected_ready", 32'd1, 32'd0);
      end else begin
        e = q0.pop_front();
        if (e.chk_data) check("d0_rdata", b0.mem_rdata, e.rdata);
        check("d0_fault", {31'd0, b0.mem_fault}, {31'd0, e.fault});
        check("d0_fault_addr", fa0, e.faddr);
        check("d0_latency", 32'(cyc), 32'(e.due));
      end
    end
  end

  // Monitor for instance 1.
  always @(negedge clk) begin : mon1
    exp_t e;
    if (b1.mem_ready === 1'b1) begin
      if (q1.size() == 0) begin
        check("d1_unexpected_ready", 32'd1, 32'd0);
      end else begin
        e = q1.pop_front();
        if (e.chk_data) check("d1_rdata", b1.mem_rdata, e.rdata);
        check("d1_fault", {31'd0, b1.mem_fault}, {31'd0, e.fault});
        check("d1_fault_addr", fa1, e.faddr);
        check("d1_latency", 32'(cyc), 32'(e.due));
      end
    end
  end

  // Issue one request; call just after a rising edge. Leaves mem_valid high.
  task automatic issue(input int d, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input logic instr);
    exp_t        e;
    logic        ok, got;
    int unsigned idx;
    logic [31:0] word;
    ok  = (d == 0) ? in_rng(addr, BASE0, AW0) : in_rng(addr, BASE1, AW1);
    idx = (addr - ((d == 0) ? BASE0 : BASE1)) >> 2;
    e.rdata = 32'd0; e.chk_data = 1'b1; e.fault = 1'b0;
    if (!ok) begin
      e.rdata = FAULT_RDATA; e.fault = 1'b1;
      if (d == 0) lf0 = addr; else lf1 = addr;
    end else if (wstrb == 4'd0) begin
      if (d == 0) begin e.chk_data = m0.exists(idx); if (e.chk_data) e.rdata = m0[idx]; end
      else        begin e.chk_data = m1.exists(idx); if (e.chk_data) e.rdata = m1[idx]; end
      if (d == 0) begin if (instr) cnt_if++; else cnt_rd++; end
    end else begin
      word = 32'd0;
      if (d == 0 && m0.exists(idx)) word = m0[idx];
      if (d == 1 && m1.exists(idx)) word = m1[idx];
      for (int i = 0; i < 4; i++) if (wstrb[i]) word[8*i +: 8] = wdata[8*i +: 8];
      if (d == 0) begin m0[idx] = word; cnt_wr++; end else m1[idx] = word;
    end
    e.faddr = (d == 0) ? lf0 : lf1;
    e.due   = cyc + ((d == 0) ? WS0 : WS1) + 1;
    if (d == 0) begin
      q0.push_back(e);
      b0.mem_valid = 1'b1; b0.mem_addr = addr; b0.mem_wdata = wdata;
      b0.mem_wstrb = wstrb; b0.mem_instr = instr;
      @(posedge clk); #1;
      b0.mem_addr = $urandom; b0.mem_wdata = $urandom; b0.mem_wstrb = 4'($urandom);
    end else begin
      q1.push_back(e);
      b1.mem_valid = 1'b1; b1.mem_addr = addr; b1.mem_wdata = wdata;
      b1.mem_wstrb = wstrb; b1.mem_instr = instr;
    end
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if ((d == 0 && b0.mem_ready === 1'b1) || (d == 1 && b1.mem_ready === 1'b1)) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    b0.mem_valid = 1'b0; b1.mem_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin : stim
    logic [31:0] pool0 [6];
    logic [31:0] bad0 [3];
    logic [31:0] pool1 [4];
    logic [31:0] bad1 [2];
    logic [31:0] a;
    logic [3:0]  ws;
    int          c0;
    pool0 = '{32'h0, 32'h4, 32'h10, 32'h20, 32'h100, 32'h3_FFFC};
    bad0  = '{32'h4_0000, 32'h7_FFF0, 32'hFFFF_FFFC};
    pool1 = '{32'h400, 32'h404, 32'h5A0, 32'h7FC};
    bad1  = '{32'h3FC, 32'h800};
    lf0 = 32'd0; lf1 = 32'd0;
    b0.mem_valid = 1'b0; b0.mem_instr = 1'b0; b0.mem_addr = 32'd0; b0.mem_wdata = 32'd0; b0.mem_wstrb = 4'd0;
    b1.mem_valid = 1'b0; b1.mem_instr = 1'b0; b1.mem_addr = 32'd0; b1.mem_wdata = 32'd0; b1.mem_wstrb = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", {31'd0, b0.mem_ready}, 32'd0);
    check("reset_fault", {31'd0, b0.mem_fault}, 32'd0);
    check("reset_rdata", b0.mem_rdata, 32'd0);
    check("reset_fault_addr", fa0, 32'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    foreach (pool0[i]) issue(0, pool0[i], $urandom, 4'hF, 1'b0);
    idle();
    issue(0, 32'h10, 32'h1234_5678, 4'hF, 1'b0);
    issue(0, 32'h10, 32'd0, 4'h0, 1'b0);
    idle();
    issue(0, 32'h20, 32'h1122_3344, 4'hF, 1'b0);
    issue(0, 32'h20, 32'hAABB_CCDD, 4'b0010, 1'b0);
    issue(0, 32'h20, 32'd0, 4'h0, 1'b0);
    idle();
    issue(0, 32'h4_0000, 32'd0, 4'h0, 1'b0);
    issue(0, 32'h4_0000, 32'hCAFE_F00D, 4'hF, 1'b0);
    issue(0, 32'h0, 32'd0, 4'h0, 1'b0);
    idle();

    // Reset lands in the second wait cycle of a write: it must vanish.
    c0 = cyc;
    b0.mem_valid = 1'b1; b0.mem_addr = 32'h100; b0.mem_wdata = 32'h5555_AAAA; b0.mem_wstrb = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    resetn = 1'b0; b0.mem_valid = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    lf0 = 32'd0; lf1 = 32'd0; cnt_if = 0; cnt_rd = 0; cnt_wr = 0;
    check("abort_fault_addr", fa0, 32'd0);
    check("abort_ready", {31'd0, b0.mem_ready}, 32'd0);
    @(posedge clk); #1;
    check("abort_no_ready", {31'd0, b0.mem_ready}, 32'd0);
    check("abort_cycles", 32'(cyc - c0), 32'd4);
    issue(0, 32'h100, 32'd0, 4'h0, 1'b0);
    idle();

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 5) == 0) a = bad0[$urandom_range(0, 2)];
      else a = pool0[$urandom_range(0, 5)] | 32'($urandom_range(0, 3));
      ws = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      issue(0, a, $urandom, ws, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) idle();
    end
    idle();
    issue(0, 32'h4, 32'd0, 4'h0, 1'b1);
    issue(0, 32'h10, 32'd0, 4'h0, 1'b1);
    idle();
    repeat (2) @(posedge clk);
    #1;
`ifdef NATIVE_BUS_RAM_STATS_EN
    check("stat_ifetch", si0, 32'(cnt_if));
    check("stat_read", sr0, 32'(cnt_rd));
    check("stat_write", sw0, 32'(cnt_wr));
`endif

    foreach (pool1[i]) issue(1, pool1[i], $urandom, 4'hF, 1'b0);
    issue(1, 32'h400, 32'd0, 4'h0, 1'b0);
    issue(1, 32'h404, 32'd0, 4'h0, 1'b0);
    idle();
    issue(1, 32'h3FC, 32'd0, 4'h0, 1'b0);
    issue(1, 32'h800, 32'h1111_2222, 4'hF, 1'b0);
    issue(1, 32'h7FC, 32'd0, 4'h0, 1'b0);
    idle();
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 5) == 0) a = bad1[$urandom_range(0, 1)];
      else a = pool1[$urandom_range(0, 3)] | 32'($urandom_range(0, 3));
      ws = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      issue(1, a, $urandom, ws, 1'b0);
      if ($urandom_range(0, 2) == 0) idle();
    end
    idle();
    repeat (3) @(posedge clk);
    #1;
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/native_bus_ram.md
NATIVE_BUS_RAM -- requirements
Module: native_bus_ram

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, word-index bits (depth = 2^ADDR_WIDTH 32-bit words).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte base address; SHALL be aligned to 4*2^ADDR_WIDTH.
REQ-003 SHALL have parameter WAIT_STATES, default 1, range 0..15, extra cycles inserted before mem_ready.
REQ-004 SHALL have parameter MEM_FILE, default "", hex init file; empty means no preload.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 resetn  input  1  synchronous, active-low reset.
REQ-007 mem_valid  input  1  request valid; held by master until mem_ready.
REQ-008 mem_instr  input  1  instruction fetch qualifier; affects statistics only.
REQ-009 mem_addr  input  32  byte address; bits [1:0] ignored.
REQ-010 mem_wdata  input  32  write data.
REQ-011 mem_wstrb  input  4  byte write enables; 4'b0000 = read.
REQ-012 mem_rdata  output  32  read data, valid only while mem_ready=1.
REQ-013 mem_ready  output  1  one-cycle completion pulse.
REQ-014 mem_fault  output  1  one-cycle pulse with mem_ready when the access was out of range.
REQ-015 fault_addr  output  32  byte address of most recent faulting access.

Function
REQ-016 FSM states IDLE, WAIT, RESP; SHALL leave reset in IDLE.
REQ-017 IDLE: mem_valid=1 sampled at edge -> latch addr/wdata/wstrb/instr, load wait counter = WAIT_STATES; go WAIT if WAIT_STATES>0, else perform access and go RESP.
REQ-018 WAIT: decrement counter each cycle; on counter reaching 1->0 edge perform access and go RESP.
REQ-019 Latency: mem_ready SHALL be high in exactly cycle WAIT_STATES+1 after the cycle mem_valid was first sampled in IDLE.
REQ-020 Access uses latched values only; mem_valid/addr changes during WAIT SHALL not alter the transaction.
REQ-021 Write: only lanes with mem_wstrb[i]=1 updated (byte i = bits 8i+7:8i); other bytes unchanged; mem_rdata = 0 on writes.
REQ-022 Read: mem_rdata registered from array at access edge, held for the RESP cycle only, 0 otherwise.
REQ-023 Range: in-range iff BASE_ADDR <= addr < BASE_ADDR + 4*2^ADDR_WIDTH; word index = (addr-BASE_ADDR)[ADDR_WIDTH+1:2].
REQ-024 Out-of-range: no array write; mem_rdata = 32'hDEAD_BEEF; mem_fault=1 with mem_ready; fault_addr updated at access edge.
REQ-025 RESP: mem_ready=1 for one cycle then IDLE unconditionally; mem_valid sampled during RESP SHALL NOT start a transaction.
REQ-026 Back-to-back: new request accepted earliest in the cycle after RESP.

Reset
REQ-027 resetn=0 at any edge: state IDLE, mem_ready=0, mem_fault=0, mem_rdata=0, fault_addr=0, counter=0.
REQ-028 Reset in WAIT SHALL abandon the transaction with no array write and no mem_ready.
REQ-029 Array contents SHALL NOT be cleared by reset.

Configuration
REQ-030 Macro NATIVE_BUS_RAM_STATS_EN defined: outputs stat_ifetch, stat_read, stat_write (32 bits each, saturating at 32'hFFFF_FFFF) count completed in-range instruction fetches, data reads and writes at RESP; cleared by reset.
REQ-031 Macro undefined: the three stat ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-032 Package native_bus_pkg SHALL hold the FSM state enum, FAULT_RDATA constant (32'hDEAD_BEEF) and WSTRB_W=4.
REQ-033 Sub-module native_bus_ram_array: synchronous byte-lane write RAM, one port, MEM_FILE preload via $readmemh.

Verification
REQ-034 WAIT_STATES=1: write 0x1234_5678 to 0x0000_0010, wstrb 4'hF, then read -> mem_ready 2 cycles after valid, rdata 0x1234_5678.
REQ-035 wstrb 4'b0010 write 0xAABB_CCDD to word holding 0x1122_3344 -> read returns 0x1122_CC44.
REQ-036 BASE_ADDR=0, ADDR_WIDTH=16, read 0x0004_0000 -> rdata 0xDEAD_BEEF, mem_fault=1, fault_addr=0x0004_0000, memory unchanged.
REQ-037 WAIT_STATES=3, resetn low in 2nd WAIT cycle of a write -> no mem_ready, later read of target returns old value.
REQ-038 WAIT_STATES=0, two back-to-back reads -> each mem_ready 1 cycle after valid, exactly one pulse each, no acceptance in RESP.
REQ-039 STATS_EN: 3 fetches, 2 reads, 1 write, 1 faulting read -> stat_ifetch=3, stat_read=2, stat_write=1.
